// File: rtl/slc3_pkg.sv
// Shared SLC-3 types and the memory-mapped I/O port address.
package slc3_pkg;

  localparam logic [15:0] IO_ADDR = 16'hFFFF;

  typedef logic [15:0] word_t;
  typedef logic [6:0]  seg7_t;

endpackage

// File: rtl/hex_driver.sv
// Hex nibble to active-low seven-segment decode, bit order gfedcba.
module hex_driver
  import slc3_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  always_comb begin
    seg = '1;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = '1;
    endcase
  end

endmodule

// File: rtl/mem_to_io.sv
// CPU <-> SRAM bus bridge with a memory-mapped switch/display port at IO_ADDR.
module mem_to_io #(
  parameter slc3_pkg::word_t IO_ADDR = slc3_pkg::IO_ADDR
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [19:0]          A,
  input  logic                 CE,
  input  logic                 UB,
  input  logic                 LB,
  input  logic                 OE,
  input  logic                 WE,
  input  logic [15:0]          Switches,
  inout  logic [15:0]          Data_CPU,
  inout  logic [15:0]          Data_Mem,
  output logic [3:0]           HEX0,
  output logic [3:0]           HEX1,
  output logic [3:0]           HEX2,
  output logic [3:0]           HEX3,
  output slc3_pkg::seg7_t      SEG0,
  output slc3_pkg::seg7_t      SEG1,
  output slc3_pkg::seg7_t      SEG2,
  output slc3_pkg::seg7_t      SEG3
);

  logic            io_sel;
  logic            rd;
  logic            wr;
  logic            unused_addr_hi;
  slc3_pkg::word_t disp;

  // Only the low 16 address bits are decoded; the upper nibble aliases.
  assign io_sel         = (A[15:0] == IO_ADDR);
  assign unused_addr_hi = ^A[19:16];

  // Write takes precedence: WE low suppresses the read path even with OE low.
  assign rd = ~CE & ~OE & WE;
  assign wr = ~CE & ~WE;

  assign Data_CPU = rd ? (io_sel ? Switches : Data_Mem) : 'z;
  assign Data_Mem = wr ? Data_CPU : 'z;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      disp <= '0;
    end else if (wr && io_sel) begin
      if (!UB) disp[15:8] <= Data_CPU[15:8];
      if (!LB) disp[7:0]  <= Data_CPU[7:0];
    end
  end

  assign HEX0 = disp[3:0];
  assign HEX1 = disp[7:4];
  assign HEX2 = disp[11:8];
  assign HEX3 = disp[15:12];

  hex_driver u_hex0 (.nibble(HEX0), .seg(SEG0));
  hex_driver u_hex1 (.nibble(HEX1), .seg(SEG1));
  hex_driver u_hex2 (.nibble(HEX2), .seg(SEG2));
  hex_driver u_hex3 (.nibble(HEX3), .seg(SEG3));

endmodule

// File: tb/tb_mem_to_io.sv
// Bench for mem_to_io: directed scenarios then random bus cycles against a reference model.
module tb_mem_to_io;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [19:0] a;
  logic        ce, ub, lb, oe, we;
  logic [15:0] sw;
  logic        cpu_en, mem_en;
  logic [15:0] cpu_val, mem_val;
  wire  [15:0] data_cpu;
  wire  [15:0] data_mem;
  logic [3:0]  hex0, hex1, hex2, hex3;
  logic [6:0]  seg0, seg1, seg2, seg3;

  // Bench-side bus agents: CPU and SRAM drive only when the bridge should not.
  assign data_cpu = cpu_en ? cpu_val : 'z;
  assign data_mem = mem_en ? mem_val : 'z;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [15:0] model;

  mem_to_io #(.IO_ADDR(16'hFFFF)) dut (
    .Clk(clk), .Reset(rst), .A(a), .CE(ce), .UB(ub), .LB(lb), .OE(oe), .WE(we),
    .Switches(sw), .Data_CPU(data_cpu), .Data_Mem(data_mem),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3),
    .SEG0(seg0), .SEG1(seg1), .SEG2(seg2), .SEG3(seg3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_display();
    check("hex", 32'({hex3, hex2, hex1, hex0}), 32'(model));
    check("seg", 32'({seg3, seg2, seg1, seg0}),
          32'({SEG_TAB[model[15:12]], SEG_TAB[model[11:8]],
               SEG_TAB[model[7:4]], SEG_TAB[model[3:0]]}));
  endtask

  // One bus cycle: drive after the falling edge, check buses, then the display after the rising edge.
  task automatic bus_cycle(input logic [19:0] addr, input logic c, input logic u, input logic l,
                           input logic o, input logic w, input logic [15:0] s,
                           input logic [15:0] cv, input logic [15:0] mv);
    logic is_io, is_rd, is_wr;
    @(negedge clk);
    a = addr; ce = c; ub = u; lb = l; oe = o; we = w;
    sw = s; cpu_val = cv; mem_val = mv;
    is_io  = (addr[15:0] == 16'hFFFF);
    is_rd  = !c && !o && w;
    is_wr  = !c && !w;
    cpu_en = !is_rd;
    mem_en = !is_wr;
    #1;
    check("data_cpu", 32'(data_cpu), 32'(is_rd ? (is_io ? s : mv) : cv));
    check("data_mem", 32'(data_mem), 32'(is_wr ? cv : mv));
    @(posedge clk);
    if (is_wr && is_io && !rst) begin
      if (!u) model[15:8] = cv[15:8];
      if (!l) model[7:0]  = cv[7:0];
    end
    #1;
    check_display();
  endtask

  initial begin
    rst = 1'b1; a = '0; ce = 1'b1; ub = 1'b1; lb = 1'b1; oe = 1'b1; we = 1'b1;
    sw = '0; cpu_en = 1'b1; mem_en = 1'b1; cpu_val = 16'h1111; mem_val = 16'h2222;
    model = '0;
    repeat (2) @(posedge clk);
    #1;
    check_display();
    check("rst_seg", 32'({seg3, seg2, seg1, seg0}), 32'({4{SEG_ZERO}}));
    rst = 1'b0;

    // 1: load 0xBEEF then pulse reset between edges
    bus_cycle(20'h0FFFF, 0, 0, 0, 1, 0, 16'h0000, 16'hBEEF, 16'h0);
    check("t1_hex", 32'({hex3, hex2, hex1, hex0}), 32'h0000BEEF);
    #2 rst = 1'b1;
    #1 model = '0;
    check("t1_hex_clr", 32'({hex3, hex2, hex1, hex0}), 32'h0);
    check("t1_seg_clr", 32'({seg3, seg2, seg1, seg0}), 32'({4{SEG_ZERO}}));
    // reset wins over a simultaneous I/O write
    bus_cycle(20'h0FFFF, 0, 0, 0, 1, 0, 16'h0000, 16'h7777, 16'h0);
    check("rst_prio", 32'({hex3, hex2, hex1, hex0}), 32'h0);
    rst = 1'b0;

    // 2, 3: switch read, memory read, aliased I/O read
    bus_cycle(20'h0FFFF, 0, 0, 0, 0, 1, 16'h1234, 16'h0, 16'h5A5A);
    bus_cycle(20'h00042, 0, 0, 0, 0, 1, 16'h1234, 16'h0, 16'hCAFE);
    check("t3_mem", 32'(data_cpu), 32'h0000CAFE);
    bus_cycle(20'hFFFFF, 0, 0, 0, 0, 1, 16'h4321, 16'h0, 16'hCAFE);

    // 4: full-word display write; OE low too, write still wins
    bus_cycle(20'h0FFFF, 0, 0, 0, 0, 0, 16'hFFFF, 16'hA5C3, 16'h0);
    check("t4_hex", 32'({hex3, hex2, hex1, hex0}), 32'h0000A5C3);
    check("t4_seg3", 32'(seg3), 32'(7'b0001000));
    check("t4_seg0", 32'(seg0), 32'(7'b0110000));

    // 5: byte-lane writes
    bus_cycle(20'h0FFFF, 0, 1, 0, 1, 0, 16'h0, 16'h1234, 16'h0);
    check("t5_lo", 32'({hex3, hex2, hex1, hex0}), 32'h0000A534);
    bus_cycle(20'h0FFFF, 0, 0, 1, 1, 0, 16'h0, 16'h9900, 16'h0);
    check("t5_hi", 32'({hex3, hex2, hex1, hex0}), 32'h00009934);

    // 6: non-writes leave the register alone and the bridge off the buses
    bus_cycle(20'h00010, 1, 0, 0, 0, 0, 16'h0, 16'h1357, 16'h2468);
    bus_cycle(20'h0FFFF, 1, 0, 0, 0, 0, 16'h0, 16'h1357, 16'h2468);
    bus_cycle(20'h0FFFF, 0, 0, 0, 1, 1, 16'h0, 16'h1357, 16'h2468);
    check("t6_hold", 32'({hex3, hex2, hex1, hex0}), 32'h00009934);

    for (int i = 0; i < 400; i++) begin
      logic [19:0] addr;
      addr = ($urandom_range(2) == 0) ? {4'($urandom), 16'hFFFF} : 20'($urandom);
      bus_cycle(addr, $urandom_range(3) == 0, 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      if ($urandom_range(39) == 0) begin
        #1 rst = 1'b1;
        #1 model = '0;
        check_display();
        rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
